// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic family (dividers, multipliers):
// the common three-state control FSM encoding and the default operand width.
package seq_arith_pkg;

  localparam int unsigned SEQ_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage : seq_arith_pkg

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift {rem, quo} left by one, trial-subtract the
// divisor from the widened partial remainder, keep or restore, and shift the
// resulting quotient bit into the LSB.
module div_step
  import seq_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           ge;

  // Trial subtraction on WIDTH+1 bits; a kept trial always fits back in WIDTH
  // bits because the incoming partial remainder is below the divisor.
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor_i};
    ge     = (rem_sh >= {1'b0, divisor_i});
    rem_o  = WIDTH'(ge ? trial : rem_sh);
    quo_o  = {quo_i[WIDTH-2:0], ge};
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: SEQ_DIVIDER_DIVZERO_EN -- when defined, a zero divisor
// short-circuits to DONE after a single BUSY cycle and raises div_zero.
module seq_divider
  import seq_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

`ifdef SEQ_DIVIDER_DIVZERO_EN
  localparam logic DZ_EN = 1'b1;
`else
  localparam logic DZ_EN = 1'b0;
`endif

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             dz_exit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // State, working registers and held results; reset aborts any division.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
    end
  end

  // Next-state logic: accept in IDLE/DONE, iterate in BUSY, publish results on exit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    dz_exit     = DZ_EN && (dsr_q == '0);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = BUSY;
          quo_d   = dividend;
          dsr_d   = divisor;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        // Zero-divisor shortcut: quo_q still holds the untouched dividend here.
        if (dz_exit) begin
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = quo_q;
          dz_d        = 1'b1;
        end else if (cnt_q == LAST_STEP) begin
          state_d     = DONE;
          quotient_d  = step_quo;
          remainder_d = step_rem;
          dz_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == BUSY);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = dz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): vector table plus hand sequences for
// back-to-back starts, ignored starts, mid-division reset and zero divisor.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present operands with start high; returns just after the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
  endtask

  // Latency counts the accepting edge as 1; returns at the negedge where done
  // is seen, or after a 40-cycle bound.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, bcnt, ndone;
    logic [7:0] ra, rb;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  9};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  9};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  9};
    vecs[3] = '{8'd0,   8'd5,   8'd0,   8'd0,  9};
    vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,  9};
    vecs[5] = '{8'd200, 8'd3,   8'd66,  8'd2,  9};
    vecs[6] = '{8'd9,   8'd4,   8'd2,   8'd1,  9};
    vecs[7] = '{8'd254, 8'd16,  8'd15,  8'd14, 9};
    vecs[8] = '{8'd1,   8'd255, 8'd0,   8'd1,  9};
    vecs[9] = '{8'd128, 8'd2,   8'd64,  8'd0,  9};

    reset_n  = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quo", int'(quotient), 0);
    chk("rst_rem", int'(remainder), 0);
    chk("rst_dz", int'(div_zero), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Table: first launch lands on the first edge after reset release.
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      chk($sformatf("v%0d_quo", i), int'(quotient), int'(vecs[i].q));
      chk($sformatf("v%0d_rem", i), int'(remainder), int'(vecs[i].r));
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy", i), bcnt, 8);
      chk($sformatf("v%0d_dz", i), int'(div_zero), 0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), int'(done), 0);
      chk($sformatf("v%0d_hold", i), int'(quotient), int'(vecs[i].q));
    end

    // Back-to-back: start held during DONE of 255/1 launches 5/9 with no gap.
    launch(8'd255, 8'd1);
    wait_done(lat, bcnt);
    chk("b2b1_quo", int'(quotient), 255);
    chk("b2b1_rem", int'(remainder), 0);
    dividend = 8'd5;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk);
    wait_done(lat, bcnt);
    chk("b2b2_quo", int'(quotient), 0);
    chk("b2b2_rem", int'(remainder), 5);
    chk("b2b2_lat", lat, 9);
    chk("b2b2_busy", bcnt, 8);

    // Start pulses at BUSY cycles 3 and 5 must not disturb 200/3.
    launch(8'd200, 8'd3);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      if (lat == 3 || lat == 5) begin
        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd10;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_quo", int'(quotient), 66);
    chk("ign_rem", int'(remainder), 2);
    chk("ign_lat", lat, 9);

    // Reset at BUSY cycle 4 of 200/3: outputs clear at once, no late done.
    launch(8'd200, 8'd3);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (lat < 4) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_quo", int'(quotient), 0);
    chk("mrst_rem", int'(remainder), 0);
    chk("mrst_dz", int'(div_zero), 0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mrst_quiet", ndone, 0);
    launch(8'd9, 8'd4);
    wait_done(lat, bcnt);
    chk("mrst_after_quo", int'(quotient), 2);
    chk("mrst_after_rem", int'(remainder), 1);
    chk("mrst_after_lat", lat, 9);

    // Zero divisor.
    launch(8'd77, 8'd0);
    wait_done(lat, bcnt);
    chk("dz_quo", int'(quotient), 255);
    chk("dz_rem", int'(remainder), 77);
`ifdef SEQ_DIVIDER_DIVZERO_EN
    chk("dz_flag", int'(div_zero), 1);
    chk("dz_lat", lat, 2);
`else
    chk("dz_flag", int'(div_zero), 0);
    chk("dz_lat", lat, 9);
`endif

    // Random sweep checked against q*b + r == a and r < b.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      launch(ra, rb);
      wait_done(lat, bcnt);
      chk($sformatf("rnd%0d_eq(%0d/%0d)", i, ra, rb),
          int'(quotient) * int'(rb) + int'(remainder), int'(ra));
      chk($sformatf("rnd%0d_lt", i), int'(remainder < rb), 1);
      chk($sformatf("rnd%0d_lat", i), lat, 9);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_divider
